button_press_classifier: RTL

Consumes the clean, clock-synchronous level produced by `generic_debounce` and classifies each press as short, long or (optionally) double. Emits one-cycle pulses that downstream control FSMs act on, plus a held indicator and a wrapping press counter for status display.

---
 rtl/button_press_classifier.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/button_press_classifier.sv
`default_nettype none
// ============================================================================
// Module   : button_press_classifier
// Brief    : Classifies debounced presses as short / long (/ double with
//            DOUBLE_PRESS_EN defined) and counts classified presses mod 256.
// Revision : 1.0 - initial release
// ============================================================================
module button_press_classifier #(
    parameter int LONG_CYCLES       = 50_000_000,
    parameter int DOUBLE_GAP_CYCLES = 25_000_000,
    parameter int CNT_W             = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic       held,
    output logic [7:0] press_count
);

`ifdef DOUBLE_PRESS_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESSED   = 3'd1,
        ST_LONG_HELD = 3'd2,
        ST_GAP       = 3'd3,
        ST_SECOND    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_gap_last = CNT_W'(DOUBLE_GAP_CYCLES - 1);
    logic r_double;
`else
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    // The gap window has no meaning in the three-state build.
    logic [31:0] w_unused_gap;
    assign w_unused_gap = DOUBLE_GAP_CYCLES;
`endif

    localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_short;
    logic             r_long;
    logic [7:0]       r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_count <= 8'd0;
`ifdef DOUBLE_PRESS_EN
            r_double <= 1'b0;
`endif
        end else begin
            r_short <= 1'b0;
            r_long  <= 1'b0;
`ifdef DOUBLE_PRESS_EN
            r_double <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (btn_in) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESSED: begin
                    // Release is examined first so it wins on the threshold edge.
                    if (!btn_in) begin
                        r_cnt <= '0;
`ifdef DOUBLE_PRESS_EN
                        r_state <= ST_GAP;
`else
                        r_state <= ST_IDLE;
                        r_short <= 1'b1;
                        r_count <= r_count + 8'd1;
`endif
                    end else if (r_cnt == c_long_last) begin
                        r_state <= ST_LONG_HELD;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                        r_count <= r_count + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_LONG_HELD: begin
                    if (!btn_in) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
`ifdef DOUBLE_PRESS_EN
                ST_GAP: begin
                    if (btn_in) begin
                        r_state  <= ST_SECOND;
                        r_cnt    <= '0;
                        r_double <= 1'b1;
                        r_count  <= r_count + 8'd1;
                    end else if (r_cnt == c_gap_last) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_short <= 1'b1;
                        r_count <= r_count + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SECOND: begin
                    if (!btn_in) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign short_press = r_short;
    assign long_press  = r_long;
    assign press_count = r_count;

`ifdef DOUBLE_PRESS_EN
    assign double_press = r_double;
    assign held         = (r_state == ST_PRESSED) || (r_state == ST_LONG_HELD) ||
                          (r_state == ST_SECOND);
`else
    assign double_press = 1'b0;
    assign held         = (r_state == ST_PRESSED) || (r_state == ST_LONG_HELD);
`endif

endmodule
`default_nettype wire
